// File: rtl/bist_scheduler.sv
// bist_scheduler: shares one BIST controller between NREQ requesters.
// Round-robin arbitration, START level sequencing, signature compare,
// per-requester DONE/PASS reporting and a hang watchdog with sticky error.
//
// Controller handshake (one place, all rules):
//   - A session begins when BIST_START rises; START must have been low long
//     enough for the controller to reach its wait-for-rising-START state.
//   - START is held high for the whole session; the controller raises
//     BIST_FINISH for one cycle with SIGNATURE valid in that same cycle.
//   - The scheduler then drops START and keeps it low for at least two cycles
//     and until BIST_END has been seen, before any new session may launch.
//   - BIST_FINISH seen in any state other than RUN carries no meaning.
module bist_scheduler #(
    parameter int NREQ    = 4,
    parameter int SIG_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [NREQ-1:0]  REQ,
    output logic [NREQ-1:0]  GNT,
    output logic [NREQ-1:0]  DONE,
    output logic [NREQ-1:0]  PASS,
    output logic             BIST_START,
    input  logic             BIST_END,
    input  logic             BIST_FINISH,
    input  logic [SIG_W-1:0] SIGNATURE,
    input  logic [SIG_W-1:0] GOLDEN,
    output logic             BUSY,
    output logic             TIMEOUT_ERR,
    output logic [2:0]       DBG_STATE
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_DROP   = 3'd4,
        ST_GAP    = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [NREQ-1:0]   gnt_q;
    logic [PTR_W-1:0]  gnt_idx_q;
    logic [NREQ-1:0]   done_q;
    logic [NREQ-1:0]   pass_q;
    logic              start_q;
    logic              terr_q;
    logic [NREQ-1:0]   mask_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [WD_W-1:0]   wdog_q;
    logic              gap_cnt_q;
    logic              end_seen_q;

    logic [NREQ-1:0]   elig;
    logic              pick_vld;
    logic [PTR_W-1:0]  pick_idx;
    logic [NREQ-1:0]   pick_oh;
    logic              hi_vld;
    logic [PTR_W-1:0]  hi_idx;
    logic [PTR_W-1:0]  lo_idx;
    logic [PTR_W-1:0]  ptr_after;
    logic              sig_match;

    assign elig      = REQ & ~mask_q;
    assign sig_match = (SIGNATURE == GOLDEN);
    assign ptr_after = (gnt_idx_q == PTR_W'(NREQ - 1)) ? '0 : gnt_idx_q + PTR_W'(1);

    assign GNT         = gnt_q;
    assign DONE        = done_q;
    assign PASS        = pass_q;
    assign BIST_START  = start_q;
    assign TIMEOUT_ERR = terr_q;
    assign BUSY        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign DBG_STATE   = state_q;

    // Round-robin pick: lowest eligible index at or above the pointer, else lowest overall.
    always_comb begin
        pick_vld = 1'b0;
        hi_vld   = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        pick_oh  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_vld = 1'b1;
                lo_idx   = PTR_W'(i);
                if (PTR_W'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = PTR_W'(i);
                end
            end
        end
        pick_idx = hi_vld ? hi_idx : lo_idx;
        for (int i = 0; i < NREQ; i++) begin
            pick_oh[i] = pick_vld && (PTR_W'(i) == pick_idx);
        end
    end

    // Next-state logic; FINISH has priority over watchdog expiry in RUN.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (|elig) state_nxt = ST_ARB;
            ST_ARB:    state_nxt = pick_vld ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: state_nxt = ST_RUN;
            ST_RUN: begin
                if (BIST_FINISH)            state_nxt = ST_DROP;
                else if (wdog_q == WD_LAST) state_nxt = ST_HALT;
            end
            ST_DROP:   state_nxt = ST_GAP;
            ST_GAP:    if (gap_cnt_q && (end_seen_q || BIST_END)) state_nxt = ST_IDLE;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register plus all registered outputs and bookkeeping.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            done_q     <= '0;
            pass_q     <= '0;
            start_q    <= 1'b0;
            terr_q     <= 1'b0;
            mask_q     <= '0;
            ptr_q      <= '0;
            wdog_q     <= '0;
            gap_cnt_q  <= 1'b0;
            end_seen_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            // START is high exactly while the FSM sits in RUN, so it trails GNT by one cycle.
            start_q <= (state_nxt == ST_RUN);
            done_q  <= '0;
            // A served requester becomes eligible again only after it drops REQ.
            mask_q  <= mask_q & REQ;
            case (state_q)
                ST_ARB: begin
                    if (pick_vld) begin
                        gnt_q     <= pick_oh;
                        gnt_idx_q <= pick_idx;
                    end
                    wdog_q     <= '0;
                    end_seen_q <= 1'b0;
                end
                ST_RUN: begin
                    if (wdog_q != '1) wdog_q <= wdog_q + WD_W'(1);
                    if (BIST_FINISH) begin
                        pass_q <= (pass_q & ~gnt_q) | (gnt_q & {NREQ{sig_match}});
                        done_q <= gnt_q;
                        gnt_q  <= '0;
                        mask_q <= (mask_q & REQ) | gnt_q;
                        ptr_q  <= ptr_after;
                    end else if (wdog_q == WD_LAST) begin
                        gnt_q  <= '0;
                        terr_q <= 1'b1;
                    end
                end
                ST_DROP: begin
                    gap_cnt_q <= 1'b0;
                    if (BIST_END) end_seen_q <= 1'b1;
                end
                ST_GAP: begin
                    gap_cnt_q <= 1'b1;
                    if (BIST_END) end_seen_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
